// File: rtl/box_ctrl_if.sv
// Box controller port bundle: request queue, pixel source and committed box.
// Combinational wires only; timing is owned by box_ctrl.
// master = request/pixel source side, slave = box_ctrl.
interface box_ctrl_if;
  // request channel from the face detector
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_x;
  logic [9:0] req_y;
  logic [9:0] req_width;
  logic [9:0] req_height;
  // pixel source / box pipeline status
  logic       pix_accept;
  logic       pipe_idle;
  logic       pix_stall;
  // committed box towards the box unit
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic [9:0] box_width;
  logic [9:0] box_height;
  logic       box_valid;
  // raster tracking
  logic       frame_done;
  logic [9:0] col;
  logic [9:0] row;

  modport master (
    output req_valid, req_x, req_y, req_width, req_height,
    output pix_accept, pipe_idle,
    input  req_ready, pix_stall,
    input  box_x, box_y, box_width, box_height, box_valid,
    input  frame_done, col, row
  );

  modport slave (
    input  req_valid, req_x, req_y, req_width, req_height,
    input  pix_accept, pipe_idle,
    output req_ready, pix_stall,
    output box_x, box_y, box_width, box_height, box_valid,
    output frame_done, col, row
  );
endinterface

// File: rtl/box_ctrl.sv
// Box sequencer: queues box requests, tracks raster position, commits one box per drained frame.
// Latency: committed box visible the cycle after COMMIT; frame_done one cycle after last pixel.
// Backpressure: req_ready drops when queue full; pix_stall high outside FRAME (drain + commit).
module box_ctrl #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int Q_DEPTH     = 4,
  parameter int HOLD_FRAMES = 8
) (
  input  logic     clock,
  input  logic     reset,
  box_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_FRAME  = 2'd0,
    S_DRAIN  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] w;
    logic [9:0] h;
  } req_t;

  localparam int          AW        = $clog2(Q_DEPTH);
  localparam logic [AW:0] Q_FULL    = (AW+1)'(Q_DEPTH);
  localparam logic [9:0]  COL_LAST  = 10'(IMG_WIDTH - 1);
  localparam logic [9:0]  ROW_LAST  = 10'(IMG_HEIGHT - 1);
  localparam logic [10:0] W11       = 11'(IMG_WIDTH);
  localparam logic [10:0] H11       = 11'(IMG_HEIGHT);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);

  // request queue
  req_t          q_mem [Q_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  req_t          head;

  // sequencing and raster state
  state_t        state;
  logic [9:0]    col;
  logic [9:0]    row;
  logic          frame_done;
  logic [15:0]   idle_frames;

  // committed box registers
  logic          box_valid;
  logic [9:0]    box_x;
  logic [9:0]    box_y;
  logic [9:0]    box_width;
  logic [9:0]    box_height;

  // commit evaluation of the oldest queued request
  logic          head_ok;
  logic [10:0]   rem_w;
  logic [10:0]   rem_h;
  logic [9:0]    clamp_w;
  logic [9:0]    clamp_h;

  // ready comes only from the registered count, so a full queue stays closed even while popping
  assign bus.req_ready = (count < Q_FULL);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state == S_COMMIT) && (count != '0);
  assign head          = q_mem[rd_ptr];

  // Validate and clamp the head request against the image, in 11 bits so nothing wraps
  always_comb begin
    head_ok = ({1'b0, head.x} < W11) && ({1'b0, head.y} < H11) &&
              (head.w != 10'd0) && (head.h != 10'd0);
    rem_w   = W11 - {1'b0, head.x};
    rem_h   = H11 - {1'b0, head.y};
    clamp_w = ({1'b0, head.w} < rem_w) ? head.w : rem_w[9:0];
    clamp_h = ({1'b0, head.h} < rem_h) ? head.h : rem_h[9:0];
  end

  // Queue storage write; payload needs no reset since pointers define occupancy
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      q_mem[wr_ptr] <= '{x: bus.req_x, y: bus.req_y, w: bus.req_width, h: bus.req_height};
    end
  end

  // Queue pointers and occupancy; push and pop may coincide
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Frame sequencer: raster tracking, drain wait and single-cycle box commit
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_FRAME;
      col         <= '0;
      row         <= '0;
      frame_done  <= 1'b0;
      idle_frames <= '0;
      box_valid   <= 1'b0;
      box_x       <= '0;
      box_y       <= '0;
      box_width   <= '0;
      box_height  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_FRAME: begin
          if (bus.pix_accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row        <= '0;
                frame_done <= 1'b1;
                state      <= S_DRAIN;
              end else begin
                row <= row + 10'd1;
              end
            end else begin
              col <= col + 10'd1;
            end
          end
        end

        S_DRAIN: begin
          // source is stalled here; pix_accept is a protocol error and is ignored
          if (bus.pipe_idle) state <= S_COMMIT;
        end

        S_COMMIT: begin
          state <= S_FRAME;
          if (pop) begin
            idle_frames <= '0;
            box_valid   <= head_ok;
            box_x       <= head_ok ? head.x  : 10'd0;
            box_y       <= head_ok ? head.y  : 10'd0;
            box_width   <= head_ok ? clamp_w : 10'd0;
            box_height  <= head_ok ? clamp_h : 10'd0;
          end else if (box_valid && (HOLD_FRAMES != 0)) begin
            // box ages one frame per empty commit and expires after HOLD_FRAMES of them
            if (idle_frames == HOLD_LAST) begin
              idle_frames <= '0;
              box_valid   <= 1'b0;
              box_x       <= '0;
              box_y       <= '0;
              box_width   <= '0;
              box_height  <= '0;
            end else begin
              idle_frames <= idle_frames + 16'd1;
            end
          end
        end

        default: state <= S_FRAME;
      endcase
    end
  end

  assign bus.pix_stall  = (state != S_FRAME);
  assign bus.frame_done = frame_done;
  assign bus.col        = col;
  assign bus.row        = row;
  assign bus.box_valid  = box_valid;
  assign bus.box_x      = box_x;
  assign bus.box_y      = box_y;
  assign bus.box_width  = box_width;
  assign bus.box_height = box_height;

endmodule

// File: tb/tb_box_ctrl.sv
// Randomized + directed bench for box_ctrl against a frame-level reference model.
// Small image (20x12) keeps each frame short; every cycle's outputs are compared.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_box_ctrl;
  localparam int W    = 20;
  localparam int H    = 12;
  localparam int QD   = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst;

  box_ctrl_if bus ();

  box_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .Q_DEPTH    (QD),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  // reference model state: phase 0=frame, 1=drain, 2=commit
  typedef struct {
    int x;
    int y;
    int w;
    int h;
  } req_t;

  req_t mq[$];
  int   m_phase, m_pix, m_idle;
  int   m_bx, m_by, m_bw, m_bh;
  bit   m_bv, m_done, m_push, m_commit;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   frames_seen;
  int   stall_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_box();
    m_bv = 0; m_bx = 0; m_by = 0; m_bw = 0; m_bh = 0;
  endtask

  task automatic do_commit();
    req_t r;
    if (mq.size() > 0) begin
      r = mq.pop_front();
      m_idle = 0;
      if (r.x >= W || r.y >= H || r.w == 0 || r.h == 0) begin
        clear_box();
      end else begin
        m_bv = 1;
        m_bx = r.x;
        m_by = r.y;
        m_bw = (r.w < W - r.x) ? r.w : W - r.x;
        m_bh = (r.h < H - r.y) ? r.h : H - r.y;
      end
    end else if (m_bv && HOLD != 0) begin
      m_idle++;
      if (m_idle == HOLD) begin
        clear_box();
        m_idle = 0;
      end
    end
  endtask

  // advance the model by one clock using the inputs currently driven
  task automatic model_step();
    m_push   = 0;
    m_commit = 0;
    if (rst) begin
      mq.delete();
      m_phase = 0; m_pix = 0; m_idle = 0; m_done = 0;
      clear_box();
      return;
    end
    m_push = bus.req_valid && (mq.size() < QD);
    m_done = 0;
    case (m_phase)
      0: if (bus.pix_accept) begin
           m_pix++;
           if (m_pix == W * H) begin
             m_pix   = 0;
             m_done  = 1;
             m_phase = 1;
           end
         end
      1: if (bus.pipe_idle) m_phase = 2;
      default: begin
        do_commit();
        m_commit = 1;
        m_phase  = 0;
      end
    endcase
    if (m_push)
      mq.push_back('{int'(bus.req_x), int'(bus.req_y), int'(bus.req_width), int'(bus.req_height)});
  endtask

  task automatic compare_all();
    check("col",        bus.col,        64'(m_pix % W));
    check("row",        bus.row,        64'(m_pix / W));
    check("req_ready",  bus.req_ready,  64'(mq.size() < QD));
    check("pix_stall",  bus.pix_stall,  64'(m_phase != 0));
    check("frame_done", bus.frame_done, 64'(m_done));
    check("box", {bus.box_valid, bus.box_x, bus.box_y, bus.box_width, bus.box_height},
                 {m_bv, 10'(m_bx), 10'(m_by), 10'(m_bw), 10'(m_bh)});
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
    if (bus.frame_done) frames_seen++;
    if (bus.pix_stall)  stall_cycles++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_req(input int x, input int y, input int w, input int h);
    bit ok;
    ok = 0;
    bus.req_valid  = 1'b1;
    bus.req_x      = 10'(x);
    bus.req_y      = 10'(y);
    bus.req_width  = 10'(w);
    bus.req_height = 10'(h);
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      ok = m_push;
    end
    bus.req_valid = 1'b0;
    if (!ok) check("req_timeout", 0, 1);
  endtask

  task automatic wait_commit();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      ok = m_commit;
    end
    if (!ok) check("commit_timeout", 0, 1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_width  = '0;
    bus.req_height = '0;
    bus.pix_accept = 1'b0;
    bus.pipe_idle  = 1'b1;
    frames_seen    = 0;
    stall_cycles   = 0;

    // reset state (req_valid high in the reset cycle must be ignored)
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("rst_ready", bus.req_ready, 1);
    check("rst_stall", bus.pix_stall, 0);
    check("rst_valid", bus.box_valid, 0);
    rst = 1'b0;

    // full frame, no requests, drain held busy for 20 cycles
    bus.pix_accept = 1'b1;
    bus.pipe_idle  = 1'b0;
    for (int i = 0; i < W * H + 5 && frames_seen == 0; i++) tick();
    check("t1_frames", frames_seen, 1);
    stall_cycles = 0;
    ticks(20);
    bus.pipe_idle = 1'b1;
    wait_commit();
    check("t6_stall_len", 64'(stall_cycles >= 21), 1);
    check("t1_valid", bus.box_valid, 0);

    // box request mid-frame appears only after the commit
    ticks(50);
    send_req(10, 5, 4, 4);
    ticks(10);
    check("t2_hold", bus.box_valid, 0);
    wait_commit();
    check("t2_box", {bus.box_valid, bus.box_x, bus.box_y, bus.box_width, bus.box_height},
                    {1'b1, 10'd10, 10'd5, 10'd4, 10'd4});

    // clamping at the image edge, then an out-of-range corner
    send_req(15, 9, 10, 10);
    wait_commit();
    check("t3_clamp", {bus.box_valid, bus.box_width, bus.box_height}, {1'b1, 10'd5, 10'd3});
    send_req(20, 0, 8, 8);
    wait_commit();
    check("t3_oob", {bus.box_valid, bus.box_x}, {1'b0, 10'd0});

    // five back-to-back requests into a 4-deep queue
    for (int i = 0; i < 4; i++) send_req(i, i, 3 + i, 2 + i);
    check("t4_full", bus.req_ready, 0);
    send_req(4, 4, 7, 6);
    check("t4_first", bus.box_x, 0);
    for (int i = 1; i < 5; i++) begin
      wait_commit();
      check("t4_order", bus.box_x, 64'(i));
    end

    // expiry after HOLD empty commits
    for (int i = 1; i <= HOLD; i++) begin
      wait_commit();
      check("t5_expire", bus.box_valid, 64'(i < HOLD));
    end

    // reset mid-frame flushes the queue
    send_req(2, 2, 3, 3);
    wait_commit();
    send_req(6, 6, 2, 2);
    ticks(30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_pos", {bus.col, bus.row}, 20'd0);
    check("t6_q", bus.req_ready, 1);
    check("t6_valid", bus.box_valid, 0);
    wait_commit();
    check("t6_flushed", bus.box_valid, 0);

    // randomized traffic
    for (int c = 0; c < 20000; c++) begin
      rst            = ($urandom_range(0, 2999) == 0);
      bus.req_valid  = ($urandom_range(0, 99) < 3);
      bus.req_x      = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, W + 3));
      bus.req_y      = 10'($urandom_range(0, H + 3));
      bus.req_width  = 10'($urandom_range(0, W + 4));
      bus.req_height = 10'($urandom_range(0, H + 4));
      bus.pix_accept = ($urandom_range(0, 3) != 0);
      bus.pipe_idle  = ($urandom_range(0, 1) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
